// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop stream bundle between a FIFO controller and its producer/consumer.
// The master side is the environment, the slave side is the controller.
interface dpram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM with a 1-cycle registered read port.
// Reads are prefetched so the RAM output register doubles as the FIFO head.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  dpram_fifo_ctrl_if.slave  s,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid_q;

  logic in_ready_c;
  logic push;
  logic pop;
  logic rd;

  // Handshake decode; in_ready depends only on registered state and reset.
  always_comb begin
    in_ready_c = !reset && (cnt != CNT_FULL);
    push       = s.in_valid && in_ready_c;
    pop        = out_valid_q && s.out_ready;
    rd         = !reset && (cnt != '0) && (!out_valid_q || s.out_ready);
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = ram_data_out;
  assign s.level     = cnt + CNT_W'(out_valid_q);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wptr;
  assign ram_data_in = s.in_data;
  assign ram_rd_en   = rd;
  assign ram_rd_addr = rptr;

  // cnt tracks words held in RAM; the prefetched head is counted by out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (rd)   rptr <= rptr + ADDR_W'(1);
      if (push && !rd) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!push && rd) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (rd) begin
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 16x8 dpram and a
// cycle-level reference model checked every cycle.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_data_in;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_data_out;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  dpram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .s            (bus),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural dpram: registered read, holds when idle, clears on reset.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (reset) begin
      ram_data_out <= 8'h00;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
      if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model sampled mid-cycle, advanced to the next cycle's state.
  int         m_cnt = 0;
  bit         m_ov = 1'b0;
  int         m_wptr = 0;
  int         m_rptr = 0;
  logic [7:0] m_q [$];
  bit e_ir, e_push, e_rd, e_pop;

  always @(negedge clk) begin
    if (mon_en) begin
      e_ir   = !reset && (m_cnt != 16);
      e_push = bus.in_valid && e_ir;
      e_rd   = !reset && (m_cnt != 0) && (!m_ov || bus.out_ready);
      e_pop  = m_ov && bus.out_ready;
      chk("m_in_ready", 32'(bus.in_ready), 32'(e_ir));
      chk("m_wr_en", 32'(ram_wr_en), 32'(e_push));
      if (e_push) begin
        chk("m_wr_addr", 32'(ram_wr_addr), 32'(m_wptr));
        chk("m_data_in", 32'(ram_data_in), 32'(bus.in_data));
      end
      chk("m_rd_en", 32'(ram_rd_en), 32'(e_rd));
      if (e_rd) chk("m_rd_addr", 32'(ram_rd_addr), 32'(m_rptr));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("m_level", 32'(bus.level), 32'(m_cnt + int'(m_ov)));
      if (m_ov) chk("m_out_data", 32'(bus.out_data), 32'(m_q[0]));
      if (reset) begin
        m_cnt = 0; m_ov = 1'b0; m_wptr = 0; m_rptr = 0;
        m_q.delete();
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_push) begin
          m_q.push_back(bus.in_data);
          m_wptr = (m_wptr + 1) % 16;
        end
        if (e_rd) m_rptr = (m_rptr + 1) % 16;
        m_cnt = m_cnt + int'(e_push) - int'(e_rd);
        if (e_rd) m_ov = 1'b1;
        else if (e_pop) m_ov = 1'b0;
      end
    end
  end

  task automatic drv(input logic iv, input logic [7:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    drv(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      smp;
      if (!bus.out_valid && bus.level == 5'd0) break;
      adv;
    end
    chk({tag, "_level"}, 32'(bus.level), 32'd0);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    adv;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got [$];
    logic [7:0] dnext;
    int         pushes;
    int         idx;
    bit         acc;
    logic       iv;

    reset = 1'b1;
    drv(1'b0, 8'h00, 1'b0);
    adv;
    mon_en = 1'b1;
    adv;
    smp;
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    adv;
    reset = 1'b0;

    // Single word latency.
    drv(1'b1, 8'hA5, 1'b1);
    smp;
    chk("t1_c0_wr_en", 32'(ram_wr_en), 32'd1);
    chk("t1_c0_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("t1_c0_level", 32'(bus.level), 32'd0);
    adv;
    drv(1'b0, 8'h00, 1'b1);
    smp;
    chk("t1_c1_rd_en", 32'(ram_rd_en), 32'd1);
    chk("t1_c1_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk("t1_c1_ov", 32'(bus.out_valid), 32'd0);
    chk("t1_c1_level", 32'(bus.level), 32'd1);
    adv;
    smp;
    chk("t1_c2_ov", 32'(bus.out_valid), 32'd1);
    chk("t1_c2_data", 32'(bus.out_data), 32'hA5);
    chk("t1_c2_level", 32'(bus.level), 32'd1);
    adv;
    smp;
    chk("t1_c3_ov", 32'(bus.out_valid), 32'd0);
    chk("t1_c3_level", 32'(bus.level), 32'd0);
    adv;

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 8'(i), 1'b0);
      adv;
    end
    drv(1'b1, 8'h10, 1'b0);
    smp;
    chk("t2_pre_full_ready", 32'(bus.in_ready), 32'd1);
    chk("t2_pre_full_level", 32'(bus.level), 32'd16);
    adv;
    drv(1'b1, 8'h11, 1'b0);
    smp;
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_full_wr_en", 32'(ram_wr_en), 32'd0);
    chk("t2_full_level", 32'(bus.level), 32'd17);
    chk("t2_full_ov", 32'(bus.out_valid), 32'd1);
    chk("t2_full_head", 32'(bus.out_data), 32'h00);
    adv;

    // Full-rate streaming from the full state.
    dnext  = 8'h11;
    pushes = 0;
    for (int k = 0; k < 20; k++) begin
      drv(1'b1, dnext, 1'b1);
      smp;
      chk("t3_ov", 32'(bus.out_valid), 32'd1);
      chk("t3_data", 32'(bus.out_data), 32'(k));
      acc = bus.in_ready;
      adv;
      if (acc) begin
        pushes++;
        dnext = dnext + 8'd1;
      end
    end
    chk("t3_pushes", 32'(pushes), 32'd19);
    drain("t3_drain");

    // Random valid/ready stream of 40 words.
    idx = 0;
    got.delete();
    for (int cyc = 0; cyc < 2000 && got.size() < 40; cyc++) begin
      iv = (idx < 40) && ($urandom_range(0, 1) == 1);
      drv(iv, 8'(8'h30 + idx), 1'($urandom_range(0, 1)));
      smp;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      adv;
      if (acc) idx++;
    end
    chk("t4_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size(); i++) chk("t4_data", 32'(got[i]), 32'(8'h30 + i));
    drain("t4_drain");

    // Backpressure hold then drain.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'(8'h60 + i), 1'b0);
      adv;
    end
    drv(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      smp;
      chk("t5_hold_ov", 32'(bus.out_valid), 32'd1);
      chk("t5_hold_data", 32'(bus.out_data), 32'h60);
      chk("t5_hold_rd_en", 32'(ram_rd_en), 32'd0);
      adv;
    end
    drv(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp;
      chk("t5_rel_ov", 32'(bus.out_valid), 32'd1);
      chk("t5_rel_data", 32'(bus.out_data), 32'(8'h60 + i));
      adv;
    end
    smp;
    chk("t5_end_ov", 32'(bus.out_valid), 32'd0);
    chk("t5_end_level", 32'(bus.level), 32'd0);
    adv;

    // Reset with words queued.
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, 8'(8'h80 + i), 1'b0);
      adv;
    end
    drv(1'b1, 8'h99, 1'b1);
    reset = 1'b1;
    smp;
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("t6_rst_rd_en", 32'(ram_rd_en), 32'd0);
    adv;
    reset = 1'b0;
    drv(1'b0, 8'h00, 1'b1);
    smp;
    chk("t6_post_level", 32'(bus.level), 32'd0);
    chk("t6_post_ov", 32'(bus.out_valid), 32'd0);
    chk("t6_post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_post_data", 32'(bus.out_data), 32'h00);
    adv;
    drv(1'b1, 8'h77, 1'b1);
    smp;
    chk("t6_push_wr_en", 32'(ram_wr_en), 32'd1);
    chk("t6_push_wr_addr", 32'(ram_wr_addr), 32'd0);
    adv;
    drv(1'b0, 8'h00, 1'b1);
    smp;
    chk("t6_p1_ov", 32'(bus.out_valid), 32'd0);
    adv;
    smp;
    chk("t6_p2_ov", 32'(bus.out_valid), 32'd1);
    chk("t6_p2_data", 32'(bus.out_data), 32'h77);
    adv;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("t6_tail_ov", 32'(bus.out_valid), 32'd0);
      adv;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
